// File: rtl/tensor_calc_stream_if.sv
// Stream bundle between the gradient stage and the tensor stage.
// The tensor stage connects through the slave modport.
interface tensor_calc_stream_if #(
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 16
);
  logic                        in_valid;
  logic                        in_sof;
  logic signed [IN_WIDTH-1:0]  x_in;
  logic signed [IN_WIDTH-1:0]  y_in;
  logic signed [IN_WIDTH-1:0]  t_in;
  logic                        out_valid;
  logic                        out_sof;
  logic                        out_border;
  logic signed [OUT_WIDTH-1:0] xx_smooth;
  logic signed [OUT_WIDTH-1:0] yy_smooth;
  logic signed [OUT_WIDTH-1:0] xy_smooth;
  logic signed [OUT_WIDTH-1:0] xt_smooth;
  logic signed [OUT_WIDTH-1:0] yt_smooth;
  logic signed [OUT_WIDTH-1:0] tt_smooth;

  modport master (
    output in_valid, in_sof, x_in, y_in, t_in,
    input  out_valid, out_sof, out_border,
    input  xx_smooth, yy_smooth, xy_smooth,
    input  xt_smooth, yt_smooth, tt_smooth
  );

  modport slave (
    input  in_valid, in_sof, x_in, y_in, t_in,
    output out_valid, out_sof, out_border,
    output xx_smooth, yy_smooth, xy_smooth,
    output xt_smooth, yt_smooth, tt_smooth
  );
endinterface

// File: rtl/tensor_calc_stream.sv
// Structure-tensor stage: six gradient products, round/saturate,
// then a separable [1 2 1]x[1 2 1]/16 smooth over two line buffers.
module tensor_calc_stream #(
  parameter int IN_WIDTH     = 12,
  parameter int TRUNC_WIDTH  = 14,
  parameter int OUT_WIDTH    = 16,
  parameter int SHIFT        = 2*IN_WIDTH-TRUNC_WIDTH,
  parameter int FRAME_WIDTH  = 1024,
  parameter int FRAME_HEIGHT = 768,
  parameter bit SMOOTH_EN    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  tensor_calc_stream_if.slave io
);
  localparam int PW = 2 * IN_WIDTH;
  localparam int TW = TRUNC_WIDTH;
  localparam int VW = TW + 2;
  localparam int HW = TW + 4;
  localparam int CW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int SM1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [CW-1:0] COL_LAST = CW'(FRAME_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
  localparam logic signed [PW:0] HALF =
    (SHIFT > 0) ? ((PW+1)'(1) <<< SM1) : '0;
  localparam logic signed [PW:0] SAT_HI =
    (PW+1)'((1 <<< (TW-1)) - 1);
  localparam logic signed [PW:0] SAT_LO = -SAT_HI - (PW+1)'(1);

  typedef logic signed [PW-1:0]        prod_t;
  typedef logic signed [TW-1:0]        trunc_t;
  typedef logic signed [VW-1:0]        vsum_t;
  typedef logic signed [HW-1:0]        hsum_t;
  typedef logic signed [OUT_WIDTH-1:0] out_t;

  function automatic trunc_t rnd_sat(prod_t p);
    logic signed [PW:0] q;
    q = ((PW+1)'(p) + HALF) >>> SHIFT;
    if (q > SAT_HI)      rnd_sat = trunc_t'(SAT_HI);
    else if (q < SAT_LO) rnd_sat = trunc_t'(SAT_LO);
    else                 rnd_sat = trunc_t'(q);
  endfunction

  logic [CW-1:0] col_q, col_b, col_n, col1, col2;
  logic [RW-1:0] row_q, row_b, row_n;
  logic          sof_b, bord_b;
  logic          v1, v2, v3;
  logic          sof1, sof2, sof3;
  logic          bord1, bord2, bord3;
  logic          ov_q, osof_q, obrd_q;

  prod_t  pr  [6];
  prod_t  p1  [6];
  trunc_t r2  [6];
  trunc_t r3  [6];
  vsum_t  vs  [6];
  vsum_t  s3  [6];
  vsum_t  hd1 [6];
  vsum_t  hd2 [6];
  hsum_t  hs  [6];
  out_t   sm  [6];
  out_t   o_q [6];

  trunc_t lb0 [6][FRAME_WIDTH];
  trunc_t lb1 [6][FRAME_WIDTH];

  // sof on a valid beat overrides whatever the counters hold
  always_comb begin
    sof_b  = io.in_valid & io.in_sof;
    col_b  = sof_b ? '0 : col_q;
    row_b  = sof_b ? '0 : row_q;
    col_n  = (col_b == COL_LAST) ? '0 : col_b + CW'(1);
    row_n  = row_b;
    if (col_b == COL_LAST)
      row_n = (row_b == ROW_LAST) ? '0 : row_b + RW'(1);
    bord_b = (row_b < RW'(2)) || (col_b < CW'(2));
  end

  always_comb begin
    pr[0] = PW'(io.x_in) * PW'(io.x_in);
    pr[1] = PW'(io.y_in) * PW'(io.y_in);
    pr[2] = PW'(io.x_in) * PW'(io.y_in);
    pr[3] = PW'(io.x_in) * PW'(io.t_in);
    pr[4] = PW'(io.y_in) * PW'(io.t_in);
    pr[5] = PW'(io.t_in) * PW'(io.t_in);
  end

  always_comb begin
    for (int c = 0; c < 6; c++) begin
      vs[c] = vsum_t'(lb1[c][col2])
            + (vsum_t'(lb0[c][col2]) <<< 1)
            + vsum_t'(r2[c]);
      hs[c] = hsum_t'(hd2[c])
            + (hsum_t'(hd1[c]) <<< 1)
            + hsum_t'(s3[c]);
      sm[c] = out_t'((hs[c] + hsum_t'(8)) >>> 4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      sof1   <= 1'b0;
      sof2   <= 1'b0;
      sof3   <= 1'b0;
      ov_q   <= 1'b0;
      osof_q <= 1'b0;
      obrd_q <= 1'b0;
      for (int c = 0; c < 6; c++) begin
        o_q[c] <= '0;
        hd1[c] <= '0;
        hd2[c] <= '0;
      end
    end else begin
      if (io.in_valid) begin
        col_q <= col_n;
        row_q <= row_n;
      end
      v1     <= io.in_valid;
      v2     <= v1;
      v3     <= v2;
      sof1   <= sof_b;
      sof2   <= sof1;
      sof3   <= sof2;
      ov_q   <= v3;
      osof_q <= v3 & sof3;
      obrd_q <= SMOOTH_EN & v3 & bord3;
      // taps follow valid beats only, so idle gaps leave values intact
      if (v3) begin
        for (int c = 0; c < 6; c++) begin
          hd2[c] <= hd1[c];
          hd1[c] <= s3[c];
          o_q[c] <= SMOOTH_EN ? (bord3 ? '0 : sm[c])
                              : out_t'(r3[c]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    bord1 <= bord_b;
    col1  <= col_b;
    p1    <= pr;
    bord2 <= bord1;
    col2  <= col1;
    for (int c = 0; c < 6; c++)
      r2[c] <= rnd_sat(p1[c]);
    bord3 <= bord2;
    s3    <= vs;
    r3    <= r2;
    if (v2 && !rst) begin
      for (int c = 0; c < 6; c++) begin
        lb0[c][col2] <= r2[c];
        lb1[c][col2] <= lb0[c][col2];
      end
    end
  end

  assign io.out_valid  = ov_q;
  assign io.out_sof    = osof_q;
  assign io.out_border = obrd_q;
  assign io.xx_smooth  = o_q[0];
  assign io.yy_smooth  = o_q[1];
  assign io.xy_smooth  = o_q[2];
  assign io.xt_smooth  = o_q[3];
  assign io.yt_smooth  = o_q[4];
  assign io.tt_smooth  = o_q[5];
endmodule

// File: tb/tb_tensor_calc_stream.sv
// Bench: three DUT variants share one random stream; a 2-D window
// model feeds per-DUT queues that a negedge monitor drains.
module tb_tensor_calc_stream;
  localparam int IW = 12;
  localparam int OW = 16;
  localparam int FW = 8;
  localparam int FH = 6;

  typedef struct packed {
    int                   due;
    logic                 sof;
    logic                 brd;
    logic [5:0][OW-1:0]   v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic signed [IW-1:0] x = '0;
  logic signed [IW-1:0] y = '0;
  logic signed [IW-1:0] t = '0;

  logic               ov   [3];
  logic               osof [3];
  logic               obrd [3];
  logic [5:0][OW-1:0] oval [3];

  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;
  bit   chk_idle = 1'b0;
  bit   fin_chk = 1'b0;
  bit   done = 1'b0;
  exp_t sbq [3][$];
  int   img [6][FH][FW];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tensor_calc_stream_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) ifs [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_io
    assign ifs[g].in_valid = in_valid;
    assign ifs[g].in_sof   = in_sof;
    assign ifs[g].x_in     = x;
    assign ifs[g].y_in     = y;
    assign ifs[g].t_in     = t;
    assign ov[g]   = ifs[g].out_valid;
    assign osof[g] = ifs[g].out_sof;
    assign obrd[g] = ifs[g].out_border;
    assign oval[g] = {ifs[g].tt_smooth, ifs[g].yt_smooth,
                      ifs[g].xt_smooth, ifs[g].xy_smooth,
                      ifs[g].yy_smooth, ifs[g].xx_smooth};
  end

  tensor_calc_stream #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .SMOOTH_EN(1'b1)
  ) u_smooth (.clk(clk), .rst(rst), .io(ifs[0]));

  tensor_calc_stream #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .SMOOTH_EN(1'b0)
  ) u_bypass (.clk(clk), .rst(rst), .io(ifs[1]));

  tensor_calc_stream #(
    .SHIFT(8), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
    .SMOOTH_EN(1'b0)
  ) u_bypass8 (.clk(clk), .rst(rst), .io(ifs[2]));

  function automatic int rnd(longint p, int sh);
    longint q;
    q = (sh == 0) ? p : ((p + (longint'(1) <<< (sh - 1))) >>> sh);
    if (q > 8191)  q = 8191;
    if (q < -8192) q = -8192;
    return int'(q);
  endfunction

  function automatic int wt(int i);
    return (i == 1) ? 2 : 1;
  endfunction

  task automatic beat(input logic sof, input int row, input int col,
                      input int gx, input int gy, input int gt);
    exp_t   e;
    longint p [6];
    int     s;
    in_valid = 1'b1;
    in_sof   = sof;
    x = gx[IW-1:0];
    y = gy[IW-1:0];
    t = gt[IW-1:0];
    p[0] = longint'(gx) * gx;
    p[1] = longint'(gy) * gy;
    p[2] = longint'(gx) * gy;
    p[3] = longint'(gx) * gt;
    p[4] = longint'(gy) * gt;
    p[5] = longint'(gt) * gt;
    for (int d = 0; d < 3; d++) begin
      e.due = cyc + 4;
      e.sof = sof;
      e.brd = 1'b0;
      e.v   = '0;
      for (int c = 0; c < 6; c++) begin
        s = rnd(p[c], (d == 2) ? 8 : 10);
        if (d == 0) img[c][row][col] = s;
        else        e.v[c] = OW'(s);
      end
      if (d == 0) begin
        e.brd = (row < 2) || (col < 2);
        for (int c = 0; c < 6; c++) begin
          s = 0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              if (!e.brd)
                s += wt(i) * wt(j) * img[c][row-2+i][col-2+j];
          e.v[c] = e.brd ? '0 : OW'((s + 8) >>> 4);
        end
      end
      sbq[d].push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic gen(input int kind, input int row, input int col,
                     output int gx, output int gy, output int gt);
    gx = 64; gy = 64; gt = 64;
    if (kind == 1 && !(row == 3 && col == 3)) begin
      gx = 0; gy = 0; gt = 0;
    end
    if (kind == 2) begin
      gx = int'($urandom_range(0, 4095)) - 2048;
      gy = int'($urandom_range(0, 4095)) - 2048;
      gt = int'($urandom_range(0, 4095)) - 2048;
      if (row == 0 && col == 0) begin gx = 100;   gy = -64;   gt = 32;    end
      if (row == 0 && col == 1) begin gx = -2048; gy = -2048; gt = 5;     end
      if (row == 0 && col == 2) begin gx = -2048; gy = 2047;  gt = -2048; end
      if (row == 0 && col == 3) begin gx = 2047;  gy = -2048; gt = 2047;  end
    end
  endtask

  task automatic run_frame(input int kind, input int maxgap,
                           input bit with_sof, input int n);
    int gx, gy, gt;
    for (int i = 0; i < n; i++) begin
      gen(kind, i / FW, i % FW, gx, gy, gt);
      beat(with_sof && i == 0, i / FW, i % FW, gx, gy, gt);
      if (maxgap > 0)
        repeat ($urandom_range(0, maxgap)) begin
          @(posedge clk); #1;
        end
    end
  endtask

  // beats still in flight when reset hits are dropped by the DUT
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) sbq[d].delete();
    chk_idle = 1'b1;
    @(posedge clk); #1;
    chk_idle = 1'b0;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (chk_idle) begin
        ncmp++;
        if (ov[d] !== 1'b0 || osof[d] !== 1'b0 ||
            obrd[d] !== 1'b0 || oval[d] !== '0) begin
          nfail++;
          $display("FAIL reset_state dut%0d: valid=%b sof=%b brd=%b val=%h, required all zero",
                   d, ov[d], osof[d], obrd[d], oval[d]);
        end
      end else if (ov[d] === 1'b1) begin
        ncmp++;
        if (sbq[d].size() == 0) begin
          nfail++;
          $display("FAIL unexpected_beat dut%0d cyc=%0d: got valid=1, required valid=0",
                   d, cyc);
        end else begin
          e = sbq[d].pop_front();
          if (cyc != e.due || osof[d] !== e.sof ||
              obrd[d] !== e.brd || oval[d] !== e.v) begin
            nfail++;
            $display("FAIL beat dut%0d: got cyc=%0d sof=%b brd=%b val=%h, required cyc=%0d sof=%b brd=%b val=%h",
                     d, cyc, osof[d], obrd[d], oval[d],
                     e.due, e.sof, e.brd, e.v);
          end
        end
      end
    end
    if (fin_chk && !done) begin
      for (int d = 0; d < 3; d++) begin
        ncmp++;
        if (sbq[d].size() != 0) begin
          nfail++;
          $display("FAIL missing_beats dut%0d: got %0d pending, required 0",
                   d, sbq[d].size());
        end
      end
      done = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    run_frame(0, 0, 1'b1, FW*FH);
    run_frame(1, 3, 1'b1, FW*FH);
    run_frame(2, 2, 1'b1, FW*FH);
    run_frame(2, 0, 1'b0, FW*FH);
    run_frame(0, 0, 1'b1, FW*2 + 3);
    run_frame(2, 1, 1'b1, FW*FH);
    run_frame(0, 5, 1'b1, FW*FH);
    run_frame(2, 0, 1'b1, FW + 3);
    do_reset();
    repeat (4) begin @(posedge clk); #1; end
    run_frame(0, 0, 1'b1, FW*FH);
    run_frame(2, 0, 1'b1, 5);
    do_reset();
    run_frame(1, 2, 1'b0, FW*FH);
    repeat (8) begin @(posedge clk); #1; end
    fin_chk = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    if (!done) begin
      $display("FAIL final_check: got not reached, required reached");
      $fatal(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end
endmodule
